// File: rtl/rom_load_pkg.sv
// Shared constants for the ROM download sequencer: ROM map, region indices and
// sequencer states.
package rom_load_pkg;

  localparam int unsigned ADDR_W   = 25;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned REGION_N = 4;

  localparam logic [ADDR_W-1:0] TOTAL_SIZE = 25'h0005100;

  // Region bases; each region ends where the next begins, SYNC ends at TOTAL_SIZE
  localparam logic [ADDR_W-1:0] PF_BASE   = 25'h0004000;
  localparam logic [ADDR_W-1:0] MO_BASE   = 25'h0004800;
  localparam logic [ADDR_W-1:0] SYNC_BASE = 25'h0005000;

  localparam int unsigned REG_PROG = 0;
  localparam int unsigned REG_PF   = 1;
  localparam int unsigned REG_MO   = 2;
  localparam int unsigned REG_SYNC = 3;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } load_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ROM map decode: download address to one-hot region select plus
// an in-range flag. Out-of-range addresses select no region.
module rom_region_decode
  import rom_load_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  output logic [REGION_N-1:0] region,
  output logic                in_range
);

  always_comb begin
    region   = '0;
    in_range = (addr < TOTAL_SIZE);
    if (in_range) begin
      if (addr < PF_BASE) begin
        region[REG_PROG] = 1'b1;
      end else if (addr < MO_BASE) begin
        region[REG_PF] = 1'b1;
      end else if (addr < SYNC_BASE) begin
        region[REG_MO] = 1'b1;
      end else begin
        region[REG_SYNC] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// Registers hps_io download bytes into the core ROM write port, tracks load
// completeness and sequences the core reset around downloads and user resets.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 16,
  parameter int unsigned CNT_W      = 17
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [ADDR_W-1:0]   ioctl_addr,
  input  logic [DATA_W-1:0]   ioctl_data,
  input  logic                rst_req,
  output logic [CNT_W-1:0]    dn_addr,
  output logic [DATA_W-1:0]   dn_data,
  output logic                dn_wr,
  output logic [REGION_N-1:0] region_we,
  output logic                core_reset,
  output logic                busy,
  output logic                load_ok,
  output logic                err_overflow,
  output logic                err_short
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 2) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL_SIZE);

  load_state_t         state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]    byte_cnt;
  logic                dl_q;

  logic [REGION_N-1:0] region_sel;
  logic                in_range;
  logic                accept;
  logic                reject;
  logic                dl_rise;

  rom_region_decode u_decode (
    .addr     (ioctl_addr),
    .region   (region_sel),
    .in_range (in_range)
  );

  always_comb begin
    accept  = ioctl_wr & ioctl_download & in_range;
    reject  = ioctl_wr & ioctl_download & ~in_range;
    dl_rise = ioctl_download & ~dl_q;
  end

  // Write pipeline, byte counter, error flags and reset sequencing FSM
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      byte_cnt     <= '0;
      dl_q         <= 1'b0;
      dn_addr      <= '0;
      dn_data      <= '0;
      dn_wr        <= 1'b0;
      region_we    <= '0;
      core_reset   <= 1'b1;
      busy         <= 1'b1;
      load_ok      <= 1'b0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      dn_wr     <= accept;
      region_we <= accept ? region_sel : '0;
      if (accept) begin
        dn_addr <= ioctl_addr[CNT_W-1:0];
        dn_data <= ioctl_data;
      end

      if (dl_rise) begin
        // A new download starts from a clean slate, whatever state we were in
        state        <= LOAD;
        hold_cnt     <= '0;
        byte_cnt     <= accept ? CNT_W'(1) : '0;
        err_overflow <= reject;
        err_short    <= 1'b0;
        load_ok      <= 1'b0;
        core_reset   <= 1'b1;
        busy         <= 1'b1;
      end else begin
        if (accept && (byte_cnt != CNT_MAX)) begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
        if (reject) begin
          err_overflow <= 1'b1;
        end

        case (state)
          LOAD: begin
            if (!dl_q) begin
              state     <= HOLD;
              hold_cnt  <= '0;
              load_ok   <= (byte_cnt == TOTAL_CNT) & ~err_overflow;
              err_short <= (byte_cnt < TOTAL_CNT);
            end
          end
          HOLD: begin
            if (rst_req) begin
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              state      <= RUN;
              core_reset <= 1'b0;
              busy       <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          RUN: begin
            if (rst_req) begin
              state      <= HOLD;
              hold_cnt   <= '0;
              core_reset <= 1'b1;
              busy       <= 1'b1;
            end
          end
          default: begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: randomized downloads checked against a
// scoreboard of expected ROM writes and a release-timing model.
module tb_rom_load_sequencer;

  localparam int unsigned HOLD_CYC = 16;
  localparam int unsigned TOTAL    = 32'h5100;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        rst_req;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  region_we;
  logic        core_reset;
  logic        busy;
  logic        load_ok;
  logic        err_overflow;
  logic        err_short;

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer #(.RESET_HOLD(HOLD_CYC), .CNT_W(17)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .rst_req        (rst_req),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .region_we      (region_we),
    .core_reset     (core_reset),
    .busy           (busy),
    .load_ok        (load_ok),
    .err_overflow   (err_overflow),
    .err_short      (err_short)
  );

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [3:0]  we;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   tally[4];
  int   m_count;
  bit   m_ovf;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, want, cyc);
    end
  endtask

  // ROM map from the block's address plan
  function automatic logic [3:0] region_of(input int unsigned a);
    if (a < 32'h4000) return 4'b0001;
    if (a < 32'h4800) return 4'b0010;
    if (a < 32'h5000) return 4'b0100;
    return 4'b1000;
  endfunction

  // Every dn_wr pulse must match the oldest outstanding accepted byte, one cycle late
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (dn_wr) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr", 32'(1), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(dn_addr), 32'(mon_e.addr));
          check("wr_data", 32'(dn_data), 32'(mon_e.data));
          check("wr_region", 32'(region_we), 32'(mon_e.we));
          check("wr_latency", 32'(cyc), 32'(mon_e.cyc));
        end
        for (int i = 0; i < 4; i++) tally[i] += int'(region_we[i]);
      end else if (region_we != 4'b0000) begin
        check("we_without_wr", 32'(region_we), 32'(0));
      end
    end
  end

  task automatic drive_byte(input int unsigned a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_data = d;
    if (ioctl_download && a < TOTAL) begin
      exp_q.push_back('{addr: 17'(a), data: d, we: region_of(a), cyc: cyc + 1});
      m_count++;
    end else if (ioctl_download) begin
      m_ovf = 1'b1;
    end
    @(negedge clk_sys);
  endtask

  task automatic idle();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic begin_dl();
    m_count = 0;
    m_ovf   = 1'b0;
    for (int i = 0; i < 4; i++) tally[i] = 0;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
  endtask

  // Counts clock edges until core_reset is seen low, bounded
  task automatic wait_release(input string tag, input int start, input int want);
    int n;
    n = start;
    while (core_reset && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 32'(n), 32'(want));
  endtask

  task automatic check_end_flags(input string tag);
    check({tag, "_load_ok"}, 32'(load_ok), 32'((m_count == int'(TOTAL)) && !m_ovf));
    check({tag, "_err_short"}, 32'(err_short), 32'(m_count < int'(TOTAL)));
    check({tag, "_err_ovf"}, 32'(err_overflow), 32'(m_ovf));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic check_full_tally(input string tag);
    check({tag, "_prog_cnt"}, 32'(tally[0]), 32'h4000);
    check({tag, "_pf_cnt"},   32'(tally[1]), 32'h0800);
    check({tag, "_mo_cnt"},   32'(tally[2]), 32'h0800);
    check({tag, "_sync_cnt"}, 32'(tally[3]), 32'h0100);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    rst_req        = 1'b0;
    m_count        = 0;
    m_ovf          = 1'b0;
    repeat (3) @(negedge clk_sys);

    check("rst_core_reset", 32'(core_reset), 32'(1));
    check("rst_busy", 32'(busy), 32'(1));
    check("rst_dn_wr", 32'(dn_wr), 32'(0));
    check("rst_region_we", 32'(region_we), 32'(0));
    check("rst_dn_addr", 32'(dn_addr), 32'(0));
    check("rst_dn_data", 32'(dn_data), 32'(0));
    check("rst_flags", 32'({load_ok, err_overflow, err_short}), 32'(0));

    // Power-on release
    reset = 1'b0;
    wait_release("poweron_release", 0, HOLD_CYC);
    check("poweron_busy", 32'(busy), 32'(0));

    // Writes without a download are dropped silently
    for (int i = 0; i < 8; i++) drive_byte($urandom_range(0, 32'h1FFFFFF), 8'($urandom));
    idle();
    check("nodl_flags", 32'({load_ok, err_overflow, err_short}), 32'(0));
    check("nodl_core_reset", 32'(core_reset), 32'(0));

    // Three-cycle user reset in RUN
    n = 0;
    rst_req = 1'b1;
    repeat (3) begin
      @(negedge clk_sys);
      n++;
    end
    check("rst_req_holds", 32'(core_reset), 32'(1));
    rst_req = 1'b0;
    wait_release("rst_req_release", n, 3 + HOLD_CYC);

    // Full ascending download, back-to-back, with a user reset pulse mid-load
    begin_dl();
    check("load_core_reset", 32'(core_reset), 32'(1));
    check("load_busy", 32'(busy), 32'(1));
    for (int unsigned i = 0; i < TOTAL; i++) begin
      if (i == 32'h2000) rst_req = 1'b1;
      if (i == 32'h2003) rst_req = 1'b0;
      drive_byte(i, 8'($urandom));
    end
    check("load_ignores_rst_req", 32'(core_reset), 32'(1));
    end_dl();
    // One edge to register the fall, one to leave LOAD, then the hold count
    wait_release("full_release", 0, HOLD_CYC + 2);
    check_end_flags("full");
    check_full_tally("full");

    // Short download with out-of-range writes, including the first address past the map
    begin_dl();
    for (int i = 0; i < 64; i++) begin
      drive_byte($urandom_range(0, TOTAL - 1), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    check("ovf_clear_before", 32'(err_overflow), 32'(0));
    drive_byte(TOTAL, 8'($urandom));
    idle();
    check("ovf_at_total", 32'(err_overflow), 32'(1));
    drive_byte($urandom_range(TOTAL, 32'h1FFFFFF), 8'($urandom));
    for (int i = 0; i < 64; i++) drive_byte($urandom_range(0, TOTAL - 1), 8'($urandom));
    check("ovf_sticky", 32'(err_overflow), 32'(1));
    end_dl();
    // Stop five counts into the hold period
    repeat (7) @(negedge clk_sys);
    check("ovf_end_load_ok", 32'(load_ok), 32'(0));
    check("ovf_end_short", 32'(err_short), 32'(1));
    check("ovf_end_sticky", 32'(err_overflow), 32'(1));
    check("ovf_hold_core_reset", 32'(core_reset), 32'(1));

    // New download abandons the hold; permuted order covering every address once
    begin_dl();
    check("reload_flags_cleared", 32'({load_ok, err_overflow, err_short}), 32'(0));
    for (int unsigned i = 0; i < TOTAL; i++) drive_byte((i * 32'd4661) % TOTAL, 8'($urandom));
    check("reload_still_held", 32'(core_reset), 32'(1));
    end_dl();
    wait_release("reload_release", 0, HOLD_CYC + 2);
    check_end_flags("reload");
    check_full_tally("reload");

    // Download stopping after 0x4000 writes of random in-range addresses
    begin_dl();
    for (int i = 0; i < 32'h4000; i++) begin
      drive_byte($urandom_range(0, TOTAL - 1), 8'($urandom));
      if ($urandom_range(0, 7) == 0) idle();
    end
    end_dl();
    wait_release("short_release", 0, HOLD_CYC + 2);
    check_end_flags("short");

    // Asynchronous reset in the middle of a download
    begin_dl();
    for (int unsigned i = 1; i <= 10; i++) drive_byte(i, 8'($urandom_range(1, 255)));
    idle();
    idle();
    @(posedge clk_sys);
    #2 reset = 1'b1;
    #1;
    check("async_dn_addr", 32'(dn_addr), 32'(0));
    check("async_dn_data", 32'(dn_data), 32'(0));
    check("async_core_reset", 32'(core_reset), 32'(1));
    check("async_busy", 32'(busy), 32'(1));
    @(negedge clk_sys);
    reset   = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
    @(negedge clk_sys);
    for (int i = 0; i < 256; i++) drive_byte($urandom_range(0, TOTAL - 1), 8'($urandom));
    end_dl();
    wait_release("after_reset_release", 0, HOLD_CYC + 2);
    check_end_flags("after_reset");

    repeat (2) @(negedge clk_sys);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
